// File: rtl/uart_rx_block.sv
// UART receiver (start, DATA_BITS data LSB first, optional parity, stop) sampled on an oversample tick.
// Optional parity bit and parity_err output are enabled by defining UART_RX_PARITY_EN.
`timescale 1ns/1ps

module uart_rx_block #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit          PARITY_ODD = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clk_en,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_TICK = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK} state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BREAK} state_t;
`endif

  state_t               state;
  logic                 rx_meta;
  logic                 rx_s;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  logic par_bad;
  assign par_bad = ((^shreg) ^ par_bit) != PARITY_ODD;
`endif

  assign busy = (state != ST_IDLE);

  // Line idles high, so the synchronizer resets to 1 to avoid a false start after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (clk_en) begin
        case (state)
          ST_IDLE: begin
            if (!rx_s) begin
              state    <= ST_START;
              tick_cnt <= '0;
            end
          end
          ST_START: begin
            if (tick_cnt == HALF_TICK) begin
              if (!rx_s) begin
                state    <= ST_DATA;
                tick_cnt <= '0;
                bit_cnt  <= '0;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          ST_DATA: begin
            if (tick_cnt == LAST_TICK) begin
              shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
              tick_cnt <= '0;
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                state <= ST_PARITY;
`else
                state <= ST_STOP;
`endif
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
`ifdef UART_RX_PARITY_EN
          ST_PARITY: begin
            if (tick_cnt == LAST_TICK) begin
              par_bit  <= rx_s;
              tick_cnt <= '0;
              state    <= ST_STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
`endif
          // Returning to IDLE at mid stop bit leaves half a bit to catch a back-to-back start edge.
          ST_STOP: begin
            if (tick_cnt == LAST_TICK) begin
              tick_cnt <= '0;
              if (rx_s) begin
                state <= ST_IDLE;
`ifdef UART_RX_PARITY_EN
                if (par_bad) begin
                  parity_err <= 1'b1;
                end else begin
                  rx_data  <= shreg;
                  rx_valid <= 1'b1;
                end
`else
                rx_data  <= shreg;
                rx_valid <= 1'b1;
`endif
              end else begin
                frame_err <= 1'b1;
                state     <= ST_BREAK;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          ST_BREAK: begin
            if (rx_s) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_block.sv
// Directed bench for uart_rx_block: frames are driven on rx_in, expected outputs queued in a scoreboard.
`timescale 1ns/1ps

module tb_uart_rx_block;

  localparam int unsigned OS = 16;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       clk_en = 1'b0;
  logic       rx_in  = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;
  logic       perr;

  // kind: 0 = good word, 1 = framing error, 2 = parity error
  typedef struct {
    int         kind;
    logic [7:0] data;
    bit         chk_lat;
    longint     start;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         div = 1;
  int         div_cnt = 0;
  longint     cyc = 0;
  logic [7:0] last_good = 8'h00;
  logic [7:0] partial = 8'h3C;

`ifdef UART_RX_PARITY_EN
  logic parity_err;
  logic par_next = 1'b0;
  assign perr = parity_err;

  uart_rx_block #(.OVERSAMPLE(OS), .DATA_BITS(8), .PARITY_ODD(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .rx_in(rx_in),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy),
    .parity_err(parity_err)
  );
`else
  assign perr = 1'b0;

  uart_rx_block #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .rx_in(rx_in),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
  );
`endif

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(negedge clk);
      div_cnt = (div_cnt + 1 >= div) ? 0 : div_cnt + 1;
      clk_en  = (div_cnt == 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed hang expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: every pulse must match the head of the scoreboard.
  initial begin
    exp_t   e;
    int     kind;
    longint lat;
    forever begin
      @(negedge clk);
      if (rx_valid || frame_err || perr) begin
        check("pulse_exclusive", {62'd0, rx_valid & frame_err, rx_valid & perr}, 64'd0);
        if (sb.size() == 0) begin
          check("unexpected_pulse", {61'd0, rx_valid, frame_err, perr}, 64'd0);
        end else begin
          e    = sb.pop_front();
          kind = rx_valid ? 0 : (frame_err ? 1 : 2);
          check("pulse_kind", 64'(kind), 64'(e.kind));
          check("rx_data", {56'd0, rx_data}, {56'd0, e.data});
          if (e.chk_lat) begin
            lat = cyc - e.start;
            n_cmp++;
            assert (lat >= 153 && lat <= 155) else begin
              n_err++;
              $error("FAIL latency: observed %0d clk expected 153..155 clk", lat);
            end
          end
        end
      end
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!clk_en) @(posedge clk);
    end
  endtask

  // Hold the current level for one bit period; optionally pulse the line between ticks.
  task automatic hold_bit(input logic b, input bit glitch);
    for (int t = 0; t < int'(OS); t++) begin
      wait_ticks(1);
      if (glitch && t < int'(OS) - 1) begin
        @(negedge clk); rx_in = ~b;
        @(negedge clk); rx_in = b;
      end
    end
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    @(negedge clk);
    rx_in = b;
    hold_bit(b, glitch);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_val, input int kind,
                            input bit chk_lat, input bit glitch);
    exp_t e;
    @(negedge clk);
    rx_in     = 1'b0;
    e.start   = cyc;
    e.kind    = kind;
    e.data    = (kind == 0) ? d : last_good;
    e.chk_lat = chk_lat;
    if (kind == 0) last_good = d;
    sb.push_back(e);
    hold_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) send_bit(d[i], glitch);
`ifdef UART_RX_PARITY_EN
    send_bit(par_next, glitch);
`endif
    send_bit(stop_val, glitch);
  endtask

  initial begin
    rst_n = 1'b0;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rx_data", {56'd0, rx_data}, 64'd0);
    check("reset_rx_valid", {63'd0, rx_valid}, 64'd0);
    check("reset_frame_err", {63'd0, frame_err}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(20);

    // back-to-back frames
    send_frame(8'h55, 1'b1, 0, 1'b1, 1'b0);
    send_frame(8'h81, 1'b1, 0, 1'b1, 1'b0);
    wait_ticks(20);
    check("idle_after_frames_busy", {63'd0, busy}, 64'd0);

    // start-bit glitch of 4 ticks
    @(negedge clk);
    rx_in = 1'b0;
    wait_ticks(4);
    #1 check("glitch_busy_high", {63'd0, busy}, 64'd1);
    @(negedge clk);
    rx_in = 1'b1;
    wait_ticks(16);
    check("glitch_busy_dropped", {63'd0, busy}, 64'd0);

    // framing error followed by a held-low line
    send_frame(8'hF0, 1'b0, 1, 1'b0, 1'b0);
    wait_ticks(40);
    #1 check("break_busy_high", {63'd0, busy}, 64'd1);
    @(negedge clk);
    rx_in = 1'b1;
    wait_ticks(8);
    check("break_busy_released", {63'd0, busy}, 64'd0);
    send_frame(8'h12, 1'b1, 0, 1'b1, 1'b0);
    wait_ticks(10);

    // reset in the middle of a frame
    @(negedge clk);
    rx_in = 1'b0;
    hold_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(partial[i], 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    rx_in = 1'b1;
    #1;
    check("midrst_rx_data", {56'd0, rx_data}, 64'd0);
    check("midrst_rx_valid", {63'd0, rx_valid}, 64'd0);
    check("midrst_frame_err", {63'd0, frame_err}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    last_good = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(20);
    send_frame(8'hA5, 1'b1, 0, 1'b1, 1'b0);
    wait_ticks(10);

    // sparse tick with the line toggling between ticks
    div = 7;
    wait_ticks(20);
    send_frame(8'hC3, 1'b1, 0, 1'b0, 1'b1);
    wait_ticks(10);
    check("sparse_rx_data_hold", {56'd0, rx_data}, 64'hC3);
    div = 1;
    wait_ticks(20);

`ifdef UART_RX_PARITY_EN
    par_next = 1'b1;
    send_frame(8'h07, 1'b1, 0, 1'b0, 1'b0);
    wait_ticks(10);
    par_next = 1'b0;
    send_frame(8'h07, 1'b1, 2, 1'b0, 1'b0);
    wait_ticks(10);
`endif

    wait_ticks(20);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
